id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and ALU-control decoder. Sits directly upstream of the Alu.
- Takes the decoded instruction fields and register-file read data, and builds operand A, operand B and the 4-bit operation select.
- Registers these together with the write-back and memory control bits.
- Handles pipeline stall (hold) and flush (bubble insertion).

Parameters:
- NB_DATA, 32, datapath width
- NB_REG, 5, register address width
- NB_OPE, 4, ALU operation select width

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_valid  in  1  decode stage holds a real instruction
- i_stall  in  1  hold every register
- i_flush  in  1  load a bubble
- i_instr  in  32  raw instruction word
- i_rs_data  in  32  register file rs read
- i_rt_data  in  32  register file rt read
- i_pc_next  in  32  address of the instruction following this one
- o_data_a  out  32  ALU operand A
- o_data_b  out  32  ALU operand B
- o_ope_sel  out  4  ALU operation select
- o_store_data  out  32  rt value for SW
- o_wr_reg  out  5  destination register
- o_reg_wen  out  1  register write enable
- o_mem_wen  out  1  memory write enable
- o_mem_ren  out  1  memory read enable
- o_valid  out  1  stage holds a real instruction
- o_illegal  out  1  unsupported opcode or funct was captured

Behaviour:
- Reset (i_rst=0, asynchronous): every output is 0. o_ope_sel=0 (AND).
- Latency: exactly 1 cycle from the inputs to the registered outputs. The decode logic is combinational in front of the registers.
- Priority per edge: reset > i_flush > i_stall > load.
  - Flush loads a bubble: all outputs 0.
  - Stall holds all outputs unchanged.
  - Flush and stall asserted together: flush wins.
- i_valid=0 with no stall or flush: load a bubble.
- ALU select codes:
  - AND=0, OR=1, ADD=2, XOR=3, SUB=6, SLT=7
  - SLL=8, SRL=9, SRA=10, NOR=12, JAL=13, LUI=14
- Field definitions: op=instr[31:26], funct=[5:0], shamt=[10:6], imm=[15:0].
  - sx = sign-extended imm.
  - zx = zero-extended imm.
- R-type (op=0):
  - SLL/SRL/SRA (funct 00/02/03): A={27'b0,shamt}, B=rt.
  - SLLV/SRLV/SRAV (funct 04/06/07): A={27'b0,rs[4:0]}, B=rt.
  - ADDU 21→ADD, SUBU 23→SUB, AND 24, OR 25, XOR 26, NOR 27, SLT 2A: A=rs, B=rt.
  - wr_reg=rd, reg_wen=1.
  - JALR (funct 09): JAL, A=i_pc_next, B=4, wr_reg=rd, reg_wen=1.
- I-type:
  - ADDIU 09: ADD, A=rs, B=sx.
  - SLTI 0A: SLT, A=rs, B=sx.
  - ANDI 0C: AND, B=zx.
  - ORI 0D: OR, B=zx.
  - XORI 0E: XOR, B=zx.
  - LUI 0F: LUI, A=0, B=zx.
  - All of the above: wr_reg=rt, reg_wen=1.
  - LW 23: ADD, A=rs, B=sx, mem_ren=1, reg_wen=1, wr_reg=rt.
  - SW 2B: ADD, A=rs, B=sx, mem_wen=1, reg_wen=0.
  - BEQ 04 / BNE 05: SUB, A=rs, B=rt, no writes.
  - JAL 03: JAL, A=i_pc_next, B=4, wr_reg=31, reg_wen=1.
- o_store_data = rt for every instruction.
- Any other op or funct:
  - o_ope_sel=15, o_illegal=1.
  - All enables 0, o_valid=1.
- wr_reg=0 forces reg_wen=0.
- Reset deasserted mid-stall: the outputs stay at the reset bubble until the first non-stalled edge.

Optional Feature:
- Macro: ID_EX_FORWARDING_EN.
- When defined:
  - Extra inputs: i_exm_wr_reg[5], i_exm_reg_wen, i_exm_data[32], i_mwb_wr_reg[5], i_mwb_reg_wen, i_mwb_data[32].
  - The rs and rt values are replaced before operand selection, including store data.
  - Priority: EX/MEM match > MEM/WB match > register file.
  - Register 0 is never forwarded.
- When not defined:
  - The extra ports are absent and rs/rt come straight from the register file.
  - Hazards are handled by stalls elsewhere.

Test Plan:
- Reset low, then release; first edge with valid=0 → all outputs 0. Then ADDU $3,$1,$2 with rs=255, rt=1 → next edge o_ope_sel=2, A=255, B=1, wr_reg=3, reg_wen=1, o_valid=1.
- SRA $4,$5,4 (instr 0x00052103), rt=0xE0000080 → o_ope_sel=10, A=4, B=0xE0000080, wr_reg=4.
- ADDIU with imm=0xFFFC, then ORI with imm=0xFFFC → B=0xFFFFFFFC then B=0x0000FFFC. LUI imm=0x9FFF → o_ope_sel=14, B=0x00009FFF, wr_reg=rt.
- LW then stall for 2 cycles with new instructions presented → outputs frozen at the LW values (mem_ren=1). Stall and flush together → bubble, all outputs 0.
- JAL with i_pc_next=0x10 → o_ope_sel=13, A=0x10, B=4, wr_reg=31. op=0x3F → o_ope_sel=15, o_illegal=1, reg_wen=0.
- ID_EX_FORWARDING_EN: EX/MEM and MEM/WB both target rs=7, with data 0xAA and 0xBB → A=0xAA. rs=0 with a matching wr_reg=0 → register file value used.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_stage
// Brief   : ID/EX pipeline register with ALU-control decode, stall and flush.
//           Optional operand forwarding when ID_EX_FORWARDING_EN is defined.
// Revision: 1.0
// ============================================================================
module id_ex_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_OPE  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [31:0]        i_instr,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [NB_DATA-1:0] i_pc_next,
`ifdef ID_EX_FORWARDING_EN
  input  logic [NB_REG-1:0]  i_exm_wr_reg,
  input  logic               i_exm_reg_wen,
  input  logic [NB_DATA-1:0] i_exm_data,
  input  logic [NB_REG-1:0]  i_mwb_wr_reg,
  input  logic               i_mwb_reg_wen,
  input  logic [NB_DATA-1:0] i_mwb_data,
`endif
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OPE-1:0]  o_ope_sel,
  output logic [NB_DATA-1:0] o_store_data,
  output logic [NB_REG-1:0]  o_wr_reg,
  output logic               o_reg_wen,
  output logic               o_mem_wen,
  output logic               o_mem_ren,
  output logic               o_valid,
  output logic               o_illegal
);

  localparam logic [NB_OPE-1:0] c_ALU_AND = 4'd0,  c_ALU_OR  = 4'd1,  c_ALU_ADD = 4'd2;
  localparam logic [NB_OPE-1:0] c_ALU_XOR = 4'd3,  c_ALU_SUB = 4'd6,  c_ALU_SLT = 4'd7;
  localparam logic [NB_OPE-1:0] c_ALU_SLL = 4'd8,  c_ALU_SRL = 4'd9,  c_ALU_SRA = 4'd10;
  localparam logic [NB_OPE-1:0] c_ALU_NOR = 4'd12, c_ALU_JAL = 4'd13, c_ALU_LUI = 4'd14;
  localparam logic [NB_OPE-1:0] c_ALU_BAD = 4'd15;

  typedef struct packed {
    logic [NB_DATA-1:0] a;
    logic [NB_DATA-1:0] b;
    logic [NB_OPE-1:0]  ope;
    logic [NB_DATA-1:0] store;
    logic [NB_REG-1:0]  wr_reg;
    logic               reg_wen;
    logic               mem_wen;
    logic               mem_ren;
    logic               valid;
    logic               illegal;
  } pipe_t;

  logic [5:0]         w_op, w_funct;
  logic [4:0]         w_rs_idx, w_rt_idx, w_rd_idx, w_shamt;
  logic [NB_DATA-1:0] w_sx, w_zx, w_rs, w_rt;
  logic               w_bad;
  pipe_t              w_dec, w_pipe_d, r_pipe_q;

  assign w_op     = i_instr[31:26];
  assign w_rs_idx = i_instr[25:21];
  assign w_rt_idx = i_instr[20:16];
  assign w_rd_idx = i_instr[15:11];
  assign w_shamt  = i_instr[10:6];
  assign w_funct  = i_instr[5:0];
  assign w_sx     = {{(NB_DATA-16){i_instr[15]}}, i_instr[15:0]};
  assign w_zx     = {{(NB_DATA-16){1'b0}}, i_instr[15:0]};

`ifdef ID_EX_FORWARDING_EN
  // Youngest producer wins; $0 is hard-wired and never forwarded.
  assign w_rs = (i_exm_reg_wen && i_exm_wr_reg != '0 && i_exm_wr_reg == w_rs_idx) ? i_exm_data :
                (i_mwb_reg_wen && i_mwb_wr_reg != '0 && i_mwb_wr_reg == w_rs_idx) ? i_mwb_data :
                i_rs_data;
  assign w_rt = (i_exm_reg_wen && i_exm_wr_reg != '0 && i_exm_wr_reg == w_rt_idx) ? i_exm_data :
                (i_mwb_reg_wen && i_mwb_wr_reg != '0 && i_mwb_wr_reg == w_rt_idx) ? i_mwb_data :
                i_rt_data;
`else
  assign w_rs = i_rs_data;
  assign w_rt = i_rt_data;
`endif

  always_comb begin
    w_dec       = '0;
    w_bad       = 1'b0;
    w_dec.valid = 1'b1;
    w_dec.store = w_rt;
    w_dec.a     = w_rs;
    if (w_op == 6'h00) begin
      w_dec.b       = w_rt;
      w_dec.wr_reg  = w_rd_idx;
      w_dec.reg_wen = 1'b1;
      case (w_funct)
        6'h00: begin w_dec.ope = c_ALU_SLL; w_dec.a = NB_DATA'(w_shamt); end
        6'h02: begin w_dec.ope = c_ALU_SRL; w_dec.a = NB_DATA'(w_shamt); end
        6'h03: begin w_dec.ope = c_ALU_SRA; w_dec.a = NB_DATA'(w_shamt); end
        6'h04: begin w_dec.ope = c_ALU_SLL; w_dec.a = NB_DATA'(w_rs[4:0]); end
        6'h06: begin w_dec.ope = c_ALU_SRL; w_dec.a = NB_DATA'(w_rs[4:0]); end
        6'h07: begin w_dec.ope = c_ALU_SRA; w_dec.a = NB_DATA'(w_rs[4:0]); end
        6'h09: begin w_dec.ope = c_ALU_JAL; w_dec.a = i_pc_next; w_dec.b = NB_DATA'(4); end
        6'h21: w_dec.ope = c_ALU_ADD;
        6'h23: w_dec.ope = c_ALU_SUB;
        6'h24: w_dec.ope = c_ALU_AND;
        6'h25: w_dec.ope = c_ALU_OR;
        6'h26: w_dec.ope = c_ALU_XOR;
        6'h27: w_dec.ope = c_ALU_NOR;
        6'h2A: w_dec.ope = c_ALU_SLT;
        default: w_bad = 1'b1;
      endcase
    end else begin
      w_dec.wr_reg  = w_rt_idx;
      w_dec.reg_wen = 1'b1;
      case (w_op)
        6'h09: begin w_dec.ope = c_ALU_ADD; w_dec.b = w_sx; end
        6'h0A: begin w_dec.ope = c_ALU_SLT; w_dec.b = w_sx; end
        6'h0C: begin w_dec.ope = c_ALU_AND; w_dec.b = w_zx; end
        6'h0D: begin w_dec.ope = c_ALU_OR;  w_dec.b = w_zx; end
        6'h0E: begin w_dec.ope = c_ALU_XOR; w_dec.b = w_zx; end
        6'h0F: begin w_dec.ope = c_ALU_LUI; w_dec.a = '0; w_dec.b = w_zx; end
        6'h23: begin w_dec.ope = c_ALU_ADD; w_dec.b = w_sx; w_dec.mem_ren = 1'b1; end
        6'h2B: begin
          w_dec.ope = c_ALU_ADD; w_dec.b = w_sx; w_dec.mem_wen = 1'b1;
          w_dec.wr_reg = '0; w_dec.reg_wen = 1'b0;
        end
        6'h04, 6'h05: begin
          w_dec.ope = c_ALU_SUB; w_dec.b = w_rt;
          w_dec.wr_reg = '0; w_dec.reg_wen = 1'b0;
        end
        6'h03: begin
          w_dec.ope = c_ALU_JAL; w_dec.a = i_pc_next; w_dec.b = NB_DATA'(4);
          w_dec.wr_reg = NB_REG'(31);
        end
        default: w_bad = 1'b1;
      endcase
    end
    if (w_bad) begin
      w_dec.a       = '0;
      w_dec.b       = '0;
      w_dec.ope     = c_ALU_BAD;
      w_dec.wr_reg  = '0;
      w_dec.reg_wen = 1'b0;
      w_dec.mem_wen = 1'b0;
      w_dec.mem_ren = 1'b0;
      w_dec.illegal = 1'b1;
    end
    if (w_dec.wr_reg == '0) w_dec.reg_wen = 1'b0;
  end

  assign w_pipe_d = i_valid ? w_dec : '0;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pipe_q <= '0;
    end else if (i_flush) begin
      r_pipe_q <= '0;
    end else if (!i_stall) begin
      r_pipe_q <= w_pipe_d;
    end
  end

  assign o_data_a     = r_pipe_q.a;
  assign o_data_b     = r_pipe_q.b;
  assign o_ope_sel    = r_pipe_q.ope;
  assign o_store_data = r_pipe_q.store;
  assign o_wr_reg     = r_pipe_q.wr_reg;
  assign o_reg_wen    = r_pipe_q.reg_wen;
  assign o_mem_wen    = r_pipe_q.mem_wen;
  assign o_mem_ren    = r_pipe_q.mem_ren;
  assign o_valid      = r_pipe_q.valid;
  assign o_illegal    = r_pipe_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_stage
// Brief   : Directed and random checks of id_ex_stage against a reference model.
// Revision: 1.0
// ============================================================================
module tb_id_ex_stage;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_stall, i_flush;
  logic [31:0] i_instr, i_rs_data, i_rt_data, i_pc_next;
`ifdef ID_EX_FORWARDING_EN
  logic [4:0]  i_exm_wr_reg, i_mwb_wr_reg;
  logic        i_exm_reg_wen, i_mwb_reg_wen;
  logic [31:0] i_exm_data, i_mwb_data;
`endif
  logic [31:0] o_data_a, o_data_b, o_store_data;
  logic [3:0]  o_ope_sel;
  logic [4:0]  o_wr_reg;
  logic        o_reg_wen, o_mem_wen, o_mem_ren, o_valid, o_illegal;

  int checks = 0;
  int errors = 0;
  logic [109:0] exp_q;
  logic [109:0] w_dut;

  assign w_dut = {o_data_a, o_data_b, o_ope_sel, o_store_data, o_wr_reg,
                  o_reg_wen, o_mem_wen, o_mem_ren, o_valid, o_illegal};

  always #5 i_clk = ~i_clk;

  id_ex_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .i_instr(i_instr), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_pc_next(i_pc_next),
`ifdef ID_EX_FORWARDING_EN
    .i_exm_wr_reg(i_exm_wr_reg), .i_exm_reg_wen(i_exm_reg_wen), .i_exm_data(i_exm_data),
    .i_mwb_wr_reg(i_mwb_wr_reg), .i_mwb_reg_wen(i_mwb_reg_wen), .i_mwb_data(i_mwb_data),
`endif
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_ope_sel(o_ope_sel),
    .o_store_data(o_store_data), .o_wr_reg(o_wr_reg), .o_reg_wen(o_reg_wen),
    .o_mem_wen(o_mem_wen), .o_mem_ren(o_mem_ren), .o_valid(o_valid), .o_illegal(o_illegal)
  );

  // Architectural meaning of one instruction, packed in output order.
  function automatic logic [109:0] model(input logic [31:0] ins, input logic [31:0] rs,
                                         input logic [31:0] rt, input logic [31:0] pc);
    logic [5:0]  op, fn;
    logic [31:0] a, b, sx, zx;
    logic [3:0]  sel;
    logic [4:0]  wr;
    logic        rw, mw, mr, ill;
    op = ins[31:26]; fn = ins[5:0];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    a = rs; b = 32'h0; sel = 4'd0; wr = 5'd0; rw = 1'b0; mw = 1'b0; mr = 1'b0; ill = 1'b0;
    if (op == 6'h00) begin
      b = rt; wr = ins[15:11]; rw = 1'b1;
      if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03 || fn == 6'h04 || fn == 6'h06 || fn == 6'h07) begin
        sel = (fn[1:0] == 2'b00) ? 4'd8 : (fn[1:0] == 2'b10) ? 4'd9 : 4'd10;
        a   = fn[2] ? {27'h0, rs[4:0]} : {27'h0, ins[10:6]};
      end else if (fn == 6'h09) begin
        sel = 4'd13; a = pc; b = 32'd4;
      end else if (fn == 6'h21) sel = 4'd2;
      else if (fn == 6'h23) sel = 4'd6;
      else if (fn == 6'h24) sel = 4'd0;
      else if (fn == 6'h25) sel = 4'd1;
      else if (fn == 6'h26) sel = 4'd3;
      else if (fn == 6'h27) sel = 4'd12;
      else if (fn == 6'h2A) sel = 4'd7;
      else ill = 1'b1;
    end else begin
      wr = ins[20:16]; rw = 1'b1;
      if (op == 6'h09)      begin sel = 4'd2;  b = sx; end
      else if (op == 6'h0A) begin sel = 4'd7;  b = sx; end
      else if (op == 6'h0C) begin sel = 4'd0;  b = zx; end
      else if (op == 6'h0D) begin sel = 4'd1;  b = zx; end
      else if (op == 6'h0E) begin sel = 4'd3;  b = zx; end
      else if (op == 6'h0F) begin sel = 4'd14; a = 32'h0; b = zx; end
      else if (op == 6'h23) begin sel = 4'd2;  b = sx; mr = 1'b1; end
      else if (op == 6'h2B) begin sel = 4'd2;  b = sx; mw = 1'b1; rw = 1'b0; wr = 5'd0; end
      else if (op == 6'h04 || op == 6'h05) begin sel = 4'd6; b = rt; rw = 1'b0; wr = 5'd0; end
      else if (op == 6'h03) begin sel = 4'd13; a = pc; b = 32'd4; wr = 5'd31; end
      else ill = 1'b1;
    end
    if (ill) begin
      a = 32'h0; b = 32'h0; sel = 4'd15; wr = 5'd0; rw = 1'b0; mw = 1'b0; mr = 1'b0;
    end
    if (wr == 5'd0) rw = 1'b0;
    return {a, b, sel, rt, wr, rw, mw, mr, 1'b1, ill};
  endfunction

  task automatic chk(input string tag, input logic [109:0] obs, input logic [109:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: advance the model with the current inputs, then compare all outputs.
  task automatic step(input string tag);
    logic [31:0] rs, rt;
    rs = i_rs_data; rt = i_rt_data;
`ifdef ID_EX_FORWARDING_EN
    if (i_exm_reg_wen && i_exm_wr_reg != 0 && i_exm_wr_reg == i_instr[25:21]) rs = i_exm_data;
    else if (i_mwb_reg_wen && i_mwb_wr_reg != 0 && i_mwb_wr_reg == i_instr[25:21]) rs = i_mwb_data;
    if (i_exm_reg_wen && i_exm_wr_reg != 0 && i_exm_wr_reg == i_instr[20:16]) rt = i_exm_data;
    else if (i_mwb_reg_wen && i_mwb_wr_reg != 0 && i_mwb_wr_reg == i_instr[20:16]) rt = i_mwb_data;
`endif
    @(posedge i_clk);
    if (i_flush) exp_q = '0;
    else if (!i_stall) exp_q = i_valid ? model(i_instr, rs, rt, i_pc_next) : '0;
    #1;
    chk(tag, w_dut, exp_q);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] pc);
    i_valid = v; i_instr = ins; i_rs_data = rs; i_rt_data = rt; i_pc_next = pc;
  endtask

  logic [5:0] ops [13] = '{6'h00, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                           6'h23, 6'h2B, 6'h04, 6'h05, 6'h03, 6'h3F};
  logic [5:0] fns [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09, 6'h21,
                           6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h3B};

  initial begin
    i_rst = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef ID_EX_FORWARDING_EN
    i_exm_wr_reg = 0; i_exm_reg_wen = 0; i_exm_data = 0;
    i_mwb_wr_reg = 0; i_mwb_reg_wen = 0; i_mwb_data = 0;
`endif
    exp_q = '0;
    #12;
    chk("reset", w_dut, 110'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    step("idle_bubble");

    drive(1'b1, 32'h00221821, 32'd255, 32'd1, 32'h4);
    step("addu");
    chk("addu_fields", {o_ope_sel, o_data_a, o_data_b, o_wr_reg, o_reg_wen, o_valid},
        {4'd2, 32'd255, 32'd1, 5'd3, 1'b1, 1'b1});

    drive(1'b1, 32'h00052103, 32'h0, 32'hE0000080, 32'h8);
    step("sra");
    chk("sra_fields", {o_ope_sel, o_data_a, o_data_b, o_wr_reg},
        {4'd10, 32'd4, 32'hE0000080, 5'd4});

    drive(1'b1, 32'h2422FFFC, 32'h100, 32'h7, 32'hC);
    step("addiu");
    chk("addiu_b", o_data_b, 32'hFFFFFFFC);
    drive(1'b1, 32'h3422FFFC, 32'h100, 32'h7, 32'h10);
    step("ori");
    chk("ori_b", o_data_b, 32'h0000FFFC);
    drive(1'b1, 32'h3C029FFF, 32'h100, 32'h7, 32'h14);
    step("lui");
    chk("lui_fields", {o_ope_sel, o_data_b, o_wr_reg}, {4'd14, 32'h00009FFF, 5'd2});

    drive(1'b1, 32'h8C22FFFC, 32'h1000, 32'h55, 32'h18);
    step("lw");
    i_stall = 1'b1;
    drive(1'b1, 32'h00221821, 32'd9, 32'd9, 32'h1C);
    step("stall1");
    drive(1'b1, 32'h3422FFFC, 32'd8, 32'd8, 32'h20);
    step("stall2");
    chk("stall_mem_ren", {o_mem_ren, o_ope_sel, o_data_a}, {1'b1, 4'd2, 32'h1000});
    i_flush = 1'b1;
    step("stall_flush");
    chk("stall_flush_zero", w_dut, 110'h0);
    i_stall = 1'b0; i_flush = 1'b0;

    drive(1'b1, 32'h0C000000, 32'h3, 32'h4, 32'h10);
    step("jal");
    chk("jal_fields", {o_ope_sel, o_data_a, o_data_b, o_wr_reg, o_reg_wen},
        {4'd13, 32'h10, 32'd4, 5'd31, 1'b1});
    drive(1'b1, 32'hFC000000, 32'h3, 32'h4, 32'h14);
    step("illegal");
    chk("illegal_fields", {o_ope_sel, o_illegal, o_reg_wen, o_valid}, {4'd15, 1'b1, 1'b0, 1'b1});

    drive(1'b1, 32'h00221821, 32'd1, 32'd2, 32'h0);
    step("pre_reset");
    #2 i_rst = 1'b0;
    exp_q = '0;
    #1 chk("async_reset", w_dut, 110'h0);
    i_stall = 1'b1;
    #2 i_rst = 1'b1;
    step("reset_mid_stall");
    i_stall = 1'b0;
    step("after_stall");

`ifdef ID_EX_FORWARDING_EN
    drive(1'b1, 32'h00E21821, 32'h11, 32'h22, 32'h0);
    i_exm_wr_reg = 5'd7; i_exm_reg_wen = 1'b1; i_exm_data = 32'hAA;
    i_mwb_wr_reg = 5'd7; i_mwb_reg_wen = 1'b1; i_mwb_data = 32'hBB;
    step("fwd_both");
    chk("fwd_exm_wins", o_data_a, 32'hAA);
    drive(1'b1, 32'h00021821, 32'h11, 32'h22, 32'h0);
    i_exm_wr_reg = 5'd0; i_mwb_wr_reg = 5'd0;
    step("fwd_r0");
    chk("fwd_r0_regfile", o_data_a, 32'h11);
    i_exm_reg_wen = 1'b0; i_mwb_reg_wen = 1'b0;
`endif

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      int k;
      ins = $urandom;
      k = $urandom_range(0, 12);
      ins[31:26] = (k == 12) ? 6'($urandom) : ops[k];
      if (ins[31:26] == 6'h00) begin
        k = $urandom_range(0, 14);
        ins[5:0] = (k == 14) ? 6'($urandom) : fns[k];
      end
      if ($urandom_range(0, 7) == 0) ins[15:11] = 5'd0;
      if ($urandom_range(0, 7) == 0) ins[20:16] = 5'd0;
      drive($urandom_range(0, 9) != 0, ins, $urandom, $urandom, $urandom);
      i_stall = ($urandom_range(0, 9) == 0);
      i_flush = ($urandom_range(0, 19) == 0);
`ifdef ID_EX_FORWARDING_EN
      i_exm_wr_reg = $urandom_range(0, 1) ? ins[25:21] : 5'($urandom);
      i_mwb_wr_reg = $urandom_range(0, 1) ? ins[20:16] : 5'($urandom);
      i_exm_reg_wen = 1'($urandom); i_mwb_reg_wen = 1'($urandom);
      i_exm_data = $urandom; i_mwb_data = $urandom;
`endif
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
